// File: rtl/selector_scan_n.sv
// N-channel, W-bit registered selector with manual select and auto-scan modes.
// Scan mode rotates through unmasked channels, holding each for DWELL enabled
// cycles. Registered output with a valid flag and a wrap strobe.
module selector_scan_n #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned DWELL    = 4
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic [WIDTH*CHANNELS-1:0] iC,
  input  logic [SEL_W-1:0]          iS,
  input  logic                      iMode,
  input  logic                      iEn,
  input  logic [CHANNELS-1:0]       iMask,
  output logic [WIDTH-1:0]          oZ,
  output logic [SEL_W-1:0]          oCh,
  output logic                      oValid,
  output logic                      oWrap
);

  localparam int unsigned CntW = $clog2(DWELL) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

  typedef enum logic [1:0] {StMan, StScan, StStall} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    z_q, z_d;
  logic [SEL_W-1:0]    ch_q, ch_d;
  logic                valid_q, valid_d;
  logic                wrap_q, wrap_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                any_unmasked;
  logic                above_found;
  logic                cur_masked;
  logic                sel_legal;
  logic [SEL_W-1:0]    lowest_idx;
  logic [SEL_W-1:0]    next_idx;
  logic                advance;
  logic [SEL_W-1:0]    scan_ch;
  logic [WIDTH-1:0]    man_z;
  logic [WIDTH-1:0]    entry_z;
  logic [WIDTH-1:0]    scan_z;

  // Returns channel idx of the packed bus; out-of-range indices read as zero.
  function automatic logic [WIDTH-1:0] chan_data(input logic [SEL_W-1:0]          idx,
                                                 input logic [WIDTH*CHANNELS-1:0] bus);
    logic [WIDTH-1:0] res;
    res = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (SEL_W'(k) == idx) res = bus[k*WIDTH +: WIDTH];
    end
    return res;
  endfunction

  // Channel search: lowest unmasked, next unmasked strictly above oCh, and
  // whether the current channel / manual select are usable.
  always_comb begin
    any_unmasked = 1'b0;
    above_found  = 1'b0;
    cur_masked   = 1'b0;
    sel_legal    = 1'b0;
    lowest_idx   = '0;
    next_idx     = '0;
    // Descending walk so the last hit is the smallest qualifying index.
    for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
      if (!iMask[k]) begin
        any_unmasked = 1'b1;
        lowest_idx   = SEL_W'(k);
        if (k > int'(ch_q)) begin
          above_found = 1'b1;
          next_idx    = SEL_W'(k);
        end
      end
      if (SEL_W'(k) == ch_q) cur_masked = iMask[k];
      if (SEL_W'(k) == iS)   sel_legal  = 1'b1;
    end
    // Nothing above the current channel: wrap around to the lowest one.
    if (!above_found) next_idx = lowest_idx;
  end

  // Candidate data for each kind of update.
  always_comb begin
    advance = (cnt_q == CntLast) || cur_masked;
    scan_ch = advance ? next_idx : ch_q;
    man_z   = chan_data(iS, iC);
    entry_z = chan_data(lowest_idx, iC);
    scan_z  = chan_data(scan_ch, iC);
  end

  // Next-state and output register update; everything holds while iEn is low.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (iEn) begin
      unique case (state_q)
        StMan: begin
          cnt_d = '0;
          if (!iMode) begin
            ch_d    = iS;
            z_d     = man_z;
            valid_d = sel_legal;
          end else if (any_unmasked) begin
            state_d = StScan;
            ch_d    = lowest_idx;
            z_d     = entry_z;
            valid_d = 1'b1;
          end else begin
            state_d = StStall;
            valid_d = 1'b0;
          end
        end
        StScan: begin
          if (!iMode) begin
            state_d = StMan;
            ch_d    = iS;
            z_d     = man_z;
            valid_d = sel_legal;
            cnt_d   = '0;
          end else if (!any_unmasked) begin
            state_d = StStall;
            valid_d = 1'b0;
            cnt_d   = '0;
          end else begin
            valid_d = 1'b1;
            ch_d    = scan_ch;
            z_d     = scan_z;
            if (advance) begin
              cnt_d  = '0;
              // No unmasked channel above the old one means we went round.
              wrap_d = !above_found;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StStall: begin
          cnt_d = '0;
          if (!iMode) begin
            state_d = StMan;
            ch_d    = iS;
            z_d     = man_z;
            valid_d = sel_legal;
          end else if (any_unmasked) begin
            state_d = StScan;
            ch_d    = lowest_idx;
            z_d     = entry_z;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = StMan;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= StMan;
      z_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oZ     = z_q;
  assign oCh    = ch_q;
  assign oValid = valid_q;
  assign oWrap  = wrap_q;

endmodule

// File: tb/tb_selector_scan_n.sv
// Scoreboard bench for selector_scan_n: a 4-channel DWELL=4 instance and a
// 3-channel DWELL=1 instance, driven with directed vectors.
module tb_selector_scan_n;

  typedef struct packed {
    logic [3:0] z;
    logic [1:0] ch;
    logic       v;
    logic       w;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Instance A: 4 channels, DWELL 4
  logic [15:0] a_c = 16'hF0A5;
  logic [1:0]  a_s = '0;
  logic        a_mode = 1'b0;
  logic        a_en = 1'b0;
  logic [3:0]  a_mask = '0;
  logic [3:0]  a_z;
  logic [1:0]  a_ch;
  logic        a_valid, a_wrap;

  // Instance B: 3 channels, DWELL 1
  logic [11:0] b_c = 12'h739;
  logic [1:0]  b_s = '0;
  logic        b_mode = 1'b0;
  logic        b_en = 1'b0;
  logic [2:0]  b_mask = '0;
  logic [3:0]  b_z;
  logic [1:0]  b_ch;
  logic        b_valid, b_wrap;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks = 0;
  int   failures = 0;

  selector_scan_n #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(4)) u_a (
    .iClk(clk), .iRst_n(rst_n), .iC(a_c), .iS(a_s), .iMode(a_mode), .iEn(a_en),
    .iMask(a_mask), .oZ(a_z), .oCh(a_ch), .oValid(a_valid), .oWrap(a_wrap)
  );

  selector_scan_n #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(1)) u_b (
    .iClk(clk), .iRst_n(rst_n), .iC(b_c), .iS(b_s), .iMode(b_mode), .iEn(b_en),
    .iMask(b_mask), .oZ(b_z), .oCh(b_ch), .oValid(b_valid), .oWrap(b_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Channel data of instance A: 5, A, 0, F
  function automatic logic [3:0] da(input int k);
    logic [15:0] c;
    c = 16'hF0A5;
    return c[k*4 +: 4];
  endfunction

  // Channel data of instance B: 9, 3, 7
  function automatic logic [3:0] db(input int k);
    logic [11:0] c;
    c = 12'h739;
    return c[k*4 +: 4];
  endfunction

  task automatic step_a(input int mode, input int s, input int en, input int mask,
                        input int ez, input int ech, input int ev, input int ew);
    exp_t e;
    @(negedge clk);
    a_mode = mode[0];
    a_s    = s[1:0];
    a_en   = en[0];
    a_mask = mask[3:0];
    e.z = ez[3:0]; e.ch = ech[1:0]; e.v = ev[0]; e.w = ew[0];
    qa.push_back(e);
  endtask

  task automatic step_b(input int mode, input int s, input int en, input int mask,
                        input int ez, input int ech, input int ev, input int ew);
    exp_t e;
    @(negedge clk);
    b_mode = mode[0];
    b_s    = s[1:0];
    b_en   = en[0];
    b_mask = mask[2:0];
    e.z = ez[3:0]; e.ch = ech[1:0]; e.v = ev[0]; e.w = ew[0];
    qb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    #2;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", qa.size() + qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_z"}, int'(a_z), 0);
    check({tag, "_ch"}, int'(a_ch), 0);
    check({tag, "_valid"}, int'(a_valid), 0);
    check({tag, "_wrap"}, int'(a_wrap), 0);
  endtask

  // Monitor: outputs are registered, so each edge presents one response.
  always @(posedge clk) begin
    #1;
    if (qa.size() != 0) begin
      ea = qa.pop_front();
      check("a_z", int'(a_z), int'(ea.z));
      check("a_ch", int'(a_ch), int'(ea.ch));
      check("a_valid", int'(a_valid), int'(ea.v));
      check("a_wrap", int'(a_wrap), int'(ea.w));
    end
    if (qb.size() != 0) begin
      eb = qb.pop_front();
      check("b_z", int'(b_z), int'(eb.z));
      check("b_ch", int'(b_ch), int'(eb.ch));
      check("b_valid", int'(b_valid), int'(eb.v));
      check("b_wrap", int'(b_wrap), int'(eb.w));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ch;
    // Reset state
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Manual select, one-cycle latency
    for (int s = 0; s < 4; s++) step_a(0, s, 1, 0, da(s), s, 1, 0);

    // Full scan, no mask: 4 cycles per channel, wrap back to 0
    for (int j = 0; j < 18; j++) begin
      ch = (j / 4) % 4;
      step_a(1, 0, 1, 0, da(ch), ch, 1, (j == 16) ? 1 : 0);
    end

    // Channels 0 and 2 masked; current channel 0 masked mid-dwell advances now
    for (int k = 0; k < 17; k++) begin
      ch = ((k / 4) % 2 == 0) ? 1 : 3;
      step_a(1, 0, 1, 4'b0101, da(ch), ch, 1, (k == 8 || k == 16) ? 1 : 0);
    end

    // All masked: stall, data/channel hold
    step_a(1, 0, 1, 4'b1111, da(1), 1, 0, 0);
    step_a(1, 0, 1, 4'b1111, da(1), 1, 0, 0);
    // Unmask channel 2 only
    step_a(1, 0, 1, 4'b1011, da(2), 2, 1, 0);

    // Enable low after the 2nd dwell cycle: frozen, then 2 more cycles on ch2
    step_a(1, 0, 1, 0, da(2), 2, 1, 0);
    for (int i = 0; i < 3; i++) step_a(1, 0, 0, 0, da(2), 2, 1, 0);
    step_a(1, 0, 1, 0, da(2), 2, 1, 0);
    step_a(1, 0, 1, 0, da(2), 2, 1, 0);
    for (int i = 0; i < 4; i++) step_a(1, 0, 1, 0, da(3), 3, 1, 0);
    step_a(1, 0, 1, 0, da(0), 0, 1, 1);
    // Freeze right after a wrap: strobe must drop
    step_a(1, 0, 0, 0, da(0), 0, 1, 0);

    // Back to manual from scan, then frozen manual
    step_a(0, 2, 1, 0, da(2), 2, 1, 0);
    step_a(0, 1, 1, 0, da(1), 1, 1, 0);
    step_a(0, 3, 0, 0, da(1), 1, 1, 0);

    // Reset mid-scan
    step_a(1, 0, 1, 0, da(0), 0, 1, 0);
    step_a(1, 0, 1, 0, da(0), 0, 1, 0);
    step_a(1, 0, 1, 0, da(0), 0, 1, 0);
    drain();
    @(negedge clk);
    a_en = 1'b0;
    a_mode = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    step_a(0, 3, 1, 0, da(3), 3, 1, 0);
    step_a(0, 0, 1, 0, da(0), 0, 1, 0);
    drain();
    a_en = 1'b0;

    // Instance B: out-of-range manual select, then DWELL=1 scan
    step_b(0, 3, 1, 0, 0, 3, 0, 0);
    step_b(0, 2, 1, 0, db(2), 2, 1, 0);
    step_b(0, 3, 1, 0, 0, 3, 0, 0);
    step_b(1, 0, 1, 0, db(0), 0, 1, 0);
    step_b(1, 0, 1, 0, db(1), 1, 1, 0);
    step_b(1, 0, 1, 0, db(2), 2, 1, 0);
    step_b(1, 0, 1, 0, db(0), 0, 1, 1);
    // Single unmasked channel wraps every cycle
    step_b(1, 0, 1, 3'b110, db(0), 0, 1, 1);
    step_b(1, 0, 1, 3'b110, db(0), 0, 1, 1);
    // Stall, then manual exit
    step_b(1, 0, 1, 3'b111, db(0), 0, 0, 0);
    step_b(0, 1, 1, 3'b111, db(1), 1, 1, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
